// File: rtl/alarm_ctrl_pkg.sv
// Shared types and constants for the multi-slot alarm controller.
// State encodings are fixed so that debug and trace tools can decode them.
package alarm_ctrl_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_ENTRY        = 3'd1,
    KEY_STORED       = 3'd2,
    SHOW_ALARM       = 3'd3,
    SET_ALARM_TIME   = 3'd4,
    SET_CURRENT_TIME = 3'd5,
    KEY_WAITED       = 3'd6
  } state_t;

  localparam logic [3:0] NOKEY_DEF = 4'd10;
  localparam int         TIMER_W   = 8;

  // True in the two states that are guarded by the inactivity timeout.
  function automatic logic timed_state(state_t s);
    return (s == KEY_WAITED) || (s == KEY_ENTRY);
  endfunction

endpackage

// File: rtl/alarm_ctrl_fsm_multi_sec_timeout_cnt.sv
// Inactivity timer: counts one_second pulses up to TIMEOUT_SEC and holds.
// time_out is decoded straight from the count register.
module sec_timeout_cnt
  import alarm_ctrl_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic one_second,
  output logic time_out
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_SEC);

  logic [TIMER_W-1:0] timer;

  // Saturating seconds count, restarted whenever the owner asks.
  always_ff @(posedge clock) begin
    if (reset || clear)
      timer <= '0;
    else if (enable && one_second && timer != LIMIT)
      timer <= timer + TIMER_W'(1);
  end

  assign time_out = (timer == LIMIT);

endmodule

// File: rtl/alarm_ctrl_fsm_multi.sv
// Keypad / alarm-bank controller: sequences digit entry and load strobes.
// Moore machine; every output comes from the state or other registers.
module alarm_ctrl_fsm_multi
  import alarm_ctrl_pkg::*;
#(
  parameter int         NUM_ALARMS  = 4,
  parameter int         TIMEOUT_SEC = 10,
  parameter int         NUM_DIGITS  = 4,
  parameter logic [3:0] NOKEY       = NOKEY_DEF,
  localparam int        SLOT_W      =
    (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              one_second,
  input  logic              time_button,
  input  logic              alarm_button,
  input  logic              alarm_sel_button,
  input  logic [3:0]        key,
  output logic              reset_count,
  output logic              load_new_c,
  output logic              load_new_a,
  output logic [SLOT_W-1:0] alarm_slot,
  output logic              show_a,
  output logic              show_new_time,
  output logic              shift,
  output logic              entry_full
);

  localparam logic [3:0]        DIG_MAX  = 4'(NUM_DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_ALARMS - 1);

  state_t     state, next;
  logic [3:0] digit_cnt;
  logic       time_out;
  logic       key_hit;

  assign key_hit    = (key != NOKEY);
  assign entry_full = (digit_cnt == DIG_MAX);

  // State register.
  always_ff @(posedge clock) begin
    if (reset)
      state <= SHOW_TIME;
    else
      state <= next;
  end

  // Next-state selection; priorities inside each state matter.
  always_comb begin
    next = state;
    unique case (state)
      SHOW_TIME: begin
        if (alarm_button)
          next = SHOW_ALARM;
        else if (!alarm_sel_button && key_hit)
          next = KEY_STORED;
      end
      KEY_STORED:
        next = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_hit)
          next = KEY_ENTRY;
        else if (time_out)
          next = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)
          next = entry_full ? SET_ALARM_TIME : SHOW_TIME;
        else if (time_button)
          next = entry_full ? SET_CURRENT_TIME : SHOW_TIME;
        else if (time_out)
          next = SHOW_TIME;
        else if (key_hit && !entry_full)
          next = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button)
          next = SHOW_TIME;
      end
      SET_ALARM_TIME,
      SET_CURRENT_TIME:
        next = SHOW_TIME;
      default:
        next = SHOW_TIME;
    endcase
  end

  // Moore output decode.
  always_comb begin
    reset_count   = 1'b0;
    load_new_c    = 1'b0;
    load_new_a    = 1'b0;
    show_a        = 1'b0;
    show_new_time = 1'b0;
    shift         = 1'b0;
    unique case (state)
      KEY_STORED: begin
        shift         = 1'b1;
        show_new_time = 1'b1;
      end
      KEY_WAITED,
      KEY_ENTRY:
        show_new_time = 1'b1;
      SHOW_ALARM:
        show_a = 1'b1;
      SET_ALARM_TIME:
        load_new_a = 1'b1;
      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
      end
      default: ;
    endcase
  end

  // Digits accepted so far; idle display throws the partial entry away.
  always_ff @(posedge clock) begin
    if (reset || state == SHOW_TIME)
      digit_cnt <= '0;
    else if (state == KEY_STORED && digit_cnt != DIG_MAX)
      digit_cnt <= digit_cnt + 4'd1;
  end

  // Slot selection only moves while the time is on display.
  always_ff @(posedge clock) begin
    if (reset)
      alarm_slot <= '0;
    else if (state == SHOW_TIME && !alarm_button && alarm_sel_button)
      alarm_slot <= (alarm_slot == SLOT_MAX) ? '0
                  : alarm_slot + SLOT_W'(1);
  end

  sec_timeout_cnt #(
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .clear      ((next != state) || !timed_state(state)),
    .enable     (timed_state(state)),
    .one_second (one_second),
    .time_out   (time_out)
  );

endmodule
